// File: rtl/uart_cmd_to_btn.sv
// Pops command bytes from a show-ahead RX FIFO, decodes R/C/M into one-cycle
// button ticks and merges them with the physical debounced button ticks.
module uart_cmd_to_btn #(
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_empty,
  input  logic [7:0] i_rx_rdata,
  output logic       o_rx_pop,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  output logic       o_btn_run,
  output logic       o_btn_clear,
  output logic       o_btn_mode,
  output logic       o_cmd_err
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EMIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   byte_q;
  logic [CNT_W-1:0]    gap_cnt;
  logic                rx_pop_q;

  logic                emit_c;
  logic                dec_run_c;
  logic                dec_clear_c;
  logic                dec_mode_c;
  logic                dec_err_c;
  logic                run_tick_c;
  logic                clear_tick_c;
  logic                mode_tick_c;

  // Command sequencer; the pop strobe is registered alongside the READ entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_q   <= '0;
      gap_cnt  <= '0;
      rx_pop_q <= 1'b0;
    end else begin
      rx_pop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_rx_empty) begin
            state    <= READ;
            rx_pop_q <= 1'b1;
          end
        end
        READ: begin
          byte_q <= i_rx_rdata;
          state  <= EMIT;
        end
        EMIT: begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Case-insensitive command decode of the captured byte.
  always_comb begin
    dec_run_c   = 1'b0;
    dec_clear_c = 1'b0;
    dec_mode_c  = 1'b0;
    dec_err_c   = 1'b0;
    case (byte_q)
      8'h52, 8'h72: dec_run_c   = 1'b1;
      8'h43, 8'h63: dec_clear_c = 1'b1;
      8'h4D, 8'h6D: dec_mode_c  = 1'b1;
      default:      dec_err_c   = 1'b1;
    endcase
  end

  assign emit_c       = (state == EMIT);
  assign run_tick_c   = emit_c & dec_run_c;
  assign clear_tick_c = emit_c & dec_clear_c;
  assign mode_tick_c  = emit_c & dec_mode_c;

  assign o_rx_pop  = rx_pop_q;
  assign o_cmd_err = emit_c & dec_err_c;

  // Physical ticks bypass all state so they keep working during GAP and reset.
  assign o_btn_run   = i_btn_run   | run_tick_c;
  assign o_btn_clear = i_btn_clear | clear_tick_c;
  assign o_btn_mode  = i_btn_mode  | mode_tick_c;

endmodule

// File: tb/tb_uart_cmd_to_btn.sv
// Directed bench for uart_cmd_to_btn with a small show-ahead FIFO model.
module tb_uart_cmd_to_btn;

  localparam int unsigned GAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx_empty;
  logic [7:0] i_rx_rdata;
  logic       o_rx_pop;
  logic       i_btn_run, i_btn_clear, i_btn_mode;
  logic       o_btn_run, o_btn_clear, o_btn_mode;
  logic       o_cmd_err;

  logic [7:0] fifo_mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pop_count = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] obs;
  logic [4:0] exp_v;

  uart_cmd_to_btn #(.GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_empty (i_rx_empty),
    .i_rx_rdata (i_rx_rdata),
    .o_rx_pop   (o_rx_pop),
    .i_btn_run  (i_btn_run),
    .i_btn_clear(i_btn_clear),
    .i_btn_mode (i_btn_mode),
    .o_btn_run  (o_btn_run),
    .o_btn_clear(o_btn_clear),
    .o_btn_mode (o_btn_mode),
    .o_cmd_err  (o_cmd_err)
  );

  always #5 clk = ~clk;

  assign i_rx_empty = (rd_ptr == wr_ptr);
  assign i_rx_rdata = fifo_mem[rd_ptr[3:0]];
  assign obs        = {o_rx_pop, o_btn_run, o_btn_clear, o_btn_mode, o_cmd_err};

  always @(posedge clk) begin
    if (o_rx_pop) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_btn_run = 1'b0; i_btn_clear = 1'b1; i_btn_mode = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (obs !== 5'b00100) begin
      n_fail++; $display("FAIL reset_mirror_a got %b want %b", obs, 5'b00100);
    end
    i_btn_run = 1'b1; i_btn_clear = 1'b0; i_btn_mode = 1'b1;
    push(8'h52);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (obs !== 5'b01010) begin
        n_fail++; $display("FAIL reset_hold cycle %0d got %b want %b", c, obs, 5'b01010);
      end
    end
    i_btn_run = 1'b0; i_btn_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      exp_v = (c == 1) ? 5'b10000 : 5'b01000;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset_release cycle %0d got %b want %b", c, obs, exp_v);
      end
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_single;
    @(negedge clk);
    push(8'h52);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      exp_v = '0;
      exp_v[4] = (c == 1) || (c == 8);
      exp_v[3] = (c == 2);
      exp_v[0] = (c == 9);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL single cycle %0d got %b want %b", c, obs, exp_v);
      end
      if (c == 3) push(8'h0D);
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int pops_before;
    @(negedge clk);
    pops_before = pop_count;
    push(8'h63); push(8'h4D); push(8'h78);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk); #1;
      exp_v = '0;
      exp_v[4] = (c == 1) || (c == 8) || (c == 15);
      exp_v[2] = (c == 2);
      exp_v[1] = (c == 9);
      exp_v[0] = (c == 16);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL b2b cycle %0d got %b want %b", c, obs, exp_v);
      end
    end
    n_checks++;
    if (pop_count - pops_before !== 3) begin
      n_fail++; $display("FAIL b2b_pop_count got %0d want 3", pop_count - pops_before);
    end
    n_checks++;
    if (i_rx_empty !== 1'b1) begin
      n_fail++; $display("FAIL b2b_fifo_empty got %b want 1", i_rx_empty);
    end
  endtask

  task automatic test_decode;
    logic [7:0] bytes [0:11];
    logic [3:0] want  [0:11];
    bytes = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D,
              8'h00, 8'h0D, 8'h0A, 8'hFF, 8'h53, 8'h6E};
    want  = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0010,
              4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    for (int i = 0; i < 12; i++) begin
      push(bytes[i]);
      @(negedge clk); #1;
      n_checks++;
      if (obs !== 5'b10000) begin
        n_fail++; $display("FAIL decode_pop byte %h got %b want %b", bytes[i], obs, 5'b10000);
      end
      @(negedge clk); #1;
      n_checks++;
      if (obs !== {1'b0, want[i]}) begin
        n_fail++; $display("FAIL decode byte %h got %b want %b", bytes[i], obs, {1'b0, want[i]});
      end
      repeat (GAP + 1) @(negedge clk);
    end
  endtask

  task automatic test_merge;
    @(negedge clk);
    push(8'h43); push(8'h72);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      i_btn_mode  = (c == 4);
      i_btn_run   = (c == 9);
      i_btn_clear = (c == 9);
      #1;
      exp_v = '0;
      exp_v[4] = (c == 1) || (c == 8);
      exp_v[3] = (c == 9);
      exp_v[2] = (c == 2) || (c == 9);
      exp_v[1] = (c == 4);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL merge cycle %0d got %b want %b", c, obs, exp_v);
      end
    end
    i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int pops_before;
    @(negedge clk);
    pops_before = pop_count;
    push(8'h4D);
    @(negedge clk); #1;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++; $display("FAIL abort_pop got %b want %b", obs, 5'b10000);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (obs !== 5'b00000) begin
        n_fail++; $display("FAIL abort_in_reset step %0d got %b want %b", c, obs, 5'b00000);
      end
      @(negedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (obs !== 5'b00000) begin
        n_fail++; $display("FAIL abort_after_release cycle %0d got %b want %b", c, obs, 5'b00000);
      end
    end
    n_checks++;
    if (pop_count - pops_before !== 1) begin
      n_fail++; $display("FAIL abort_pop_count got %0d want 1", pop_count - pops_before);
    end
    // Reset in GAP, then a new byte right at release must pop on the first edge.
    push(8'h52);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(8'h6D);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      exp_v = (c == 1) ? 5'b10000 : (c == 2) ? 5'b00010 : 5'b00000;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL gap_abort_resume cycle %0d got %b want %b", c, obs, exp_v);
      end
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_idle_mirror;
    logic [2:0] r;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      r = 3'($urandom_range(0, 7));
      i_btn_run = r[2]; i_btn_clear = r[1]; i_btn_mode = r[0];
      #1;
      n_checks++;
      if (obs !== {1'b0, r, 1'b0}) begin
        n_fail++; $display("FAIL idle_mirror cycle %0d got %b want %b", c, obs, {1'b0, r, 1'b0});
      end
    end
    i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_decode;
    test_merge;
    test_reset_abort;
    test_idle_mirror;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_to_btn.md
UART_CMD_TO_BTN -- requirements
Module: uart_cmd_to_btn

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 100: number of cycles spent in GAP after each decoded byte (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_rx_empty, input, 1: receive FIFO empty flag; 1 = no byte available.
REQ-005 SHALL have port i_rx_rdata, input, 8: receive FIFO head byte (show-ahead), valid whenever i_rx_empty=0.
REQ-006 SHALL have port o_rx_pop, output, 1: one-cycle FIFO read strobe.
REQ-007 SHALL have ports i_btn_run, i_btn_clear, i_btn_mode, input, 1 each: single-cycle ticks from the physical button debouncers.
REQ-008 SHALL have ports o_btn_run, o_btn_clear, o_btn_mode, output, 1 each: merged single-cycle command ticks to the stopwatch controller.
REQ-009 SHALL have port o_cmd_err, output, 1: one-cycle tick when a popped byte is not a recognised command.

Function
REQ-010 SHALL implement FSM states IDLE, READ, EMIT, GAP, with state held in a register.
REQ-011 IDLE: SHALL go to READ on the next edge when i_rx_empty=0, otherwise stay in IDLE.
REQ-012 READ: SHALL drive o_rx_pop=1 for exactly this one cycle, capture i_rx_rdata into an 8-bit byte register on the same edge, and go to EMIT.
REQ-013 o_rx_pop SHALL be 1 only in READ; it SHALL never be 1 in any other state or while in reset.
REQ-014 EMIT: SHALL decode the captured byte and drive exactly one internal tick for this one cycle, then go to GAP.
REQ-015 Decode: 'R' (0x52) or 'r' (0x72) -> run tick; 'C' (0x43) or 'c' (0x63) -> clear tick; 'M' (0x4D) or 'm' (0x6D) -> mode tick.
REQ-016 Decode: any other value, including 0x00, 0x0D, 0x0A and 0xFF, -> o_cmd_err=1 for the EMIT cycle and no button tick.
REQ-017 GAP: SHALL count exactly GAP_CYCLES cycles using a 16-bit counter cleared on GAP entry, then return to IDLE; i_rx_empty SHALL be ignored during GAP.
REQ-018 Latency: if i_rx_empty falls while the FSM is in IDLE at cycle 0, pop is in cycle 1, the tick is in cycle 2, and the FSM is back in IDLE in cycle 3+GAP_CYCLES.
REQ-019 Back-to-back bytes: consecutive UART-generated ticks SHALL be separated by at least GAP_CYCLES+2 cycles, with no byte dropped or popped twice.
REQ-020 Merge: o_btn_x SHALL equal i_btn_x OR the internal x tick, combinationally, for each of run, clear and mode.
REQ-021 Simultaneous physical and UART ticks of the same type in one cycle SHALL produce a single 1-cycle output pulse; different types SHALL both pass unchanged.
REQ-022 Physical ticks SHALL pass through in every FSM state, including GAP, with zero-cycle latency.
REQ-023 Internal ticks and o_cmd_err SHALL be 1 only in EMIT; each is high for exactly one cycle per popped byte.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE, the GAP counter SHALL be 0, the byte register SHALL be 0x00, and o_rx_pop, o_cmd_err and all internal ticks SHALL be 0.
REQ-025 While rst=1, o_btn_x SHALL still equal i_btn_x, since the merge path is combinational.
REQ-026 Reset asserted in READ, EMIT or GAP SHALL abort immediately with no pending pop or tick.
REQ-027 After reset release, the FSM SHALL resume from IDLE on the first clock edge.

Verification
REQ-028 FIFO holds 'R' and IDLE, GAP_CYCLES=4 -> o_rx_pop=1 at cycle 1, o_btn_run=1 at cycle 2 only, IDLE at cycle 7.
REQ-029 FIFO holds 'c','M','x' back to back, GAP_CYCLES=4 -> clear tick at cycle 2, mode tick at cycle 9, o_cmd_err at cycle 16; exactly 3 pops; no other ticks.
REQ-030 i_btn_mode pulsed while the FSM is in GAP, then i_btn_run pulsed in the same cycle as a UART 'r' EMIT -> o_btn_mode passes immediately; o_btn_run is a single 1-cycle pulse.
REQ-031 rst asserted in the cycle after READ ('M' captured) -> no o_btn_mode pulse, FSM in IDLE; after release with FIFO empty, o_rx_pop stays 0.
REQ-032 i_rx_empty=1 for 1000 cycles with random physical ticks -> o_rx_pop never 1, o_cmd_err never 1, outputs mirror inputs exactly.
